instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Instruction-side responder for `cpu`. Owns a loadable instruction memory and serves fetch requests from the PC.
- Drives `cpu_instruction` and `cpu_instruction_RDY_BSY` through a request/hold/accept handshake, with configurable memory wait states and a branch flush.
- Replaces the hand-driven instruction stimulus used in CPU benches.

Parameters:
- DEPTH, 256, instruction memory depth in 32-bit words (power of 2).
- ADDR_W, 8, log2(DEPTH); word-index width.
- WAIT_STATES, 1, extra memory-access cycles per fetch (0..15).
- NOP_INSTR, 32'h0000_0013, value driven at reset and for misaligned fetches (`addi x0,x0,0`).

Ports:
- cpu_clk  in  1  clock; all state on rising edge.
- cpu_rst  in  1  synchronous active-high reset.
- pc_addr  in  32  byte address of the requested instruction.
- pc_valid  in  1  fetch request; sampled with pc_addr.
- fetch_flush  in  1  discard in-flight/held instruction (taken branch/jump).
- cpu_instr_accept  in  1  CPU consumed the held instruction.
- load_we  in  1  memory load strobe.
- load_addr  in  ADDR_W  word index to load.
- load_data  in  32  word to load.
- cpu_instruction  out  32  delivered instruction.
- cpu_instruction_RDY_BSY  out  1  1 = cpu_instruction valid and held.
- fetch_pc  out  32  byte address of cpu_instruction.
- misaligned_err  out  1  delivered instruction came from a misaligned request.
- fetch_busy  out  1  fetch in WAIT state.

Behaviour:
- Reset (synchronous, cpu_rst=1 at an edge):
  - state=IDLE, wait counter=0.
  - cpu_instruction=NOP_INSTR, cpu_instruction_RDY_BSY=0, fetch_pc=0, misaligned_err=0, fetch_busy=0.
  - Memory contents are not reset.
  - Reset mid-fetch or mid-hold abandons the transaction.
- Word index = pc_addr[ADDR_W+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH*4.
- FSM states IDLE, WAIT, HOLD.
  - IDLE: pc_valid=1 and fetch_flush=0 latches pc_addr.
    - pc_addr[1:0]!=0: go to HOLD next edge. cpu_instruction=NOP_INSTR, misaligned_err=1, no wait states.
    - WAIT_STATES=0: read memory at the same edge, go to HOLD.
    - Otherwise: go to WAIT with counter=WAIT_STATES-1.
  - WAIT: fetch_busy=1.
    - Counter≠0: decrement.
    - Counter=0: capture mem[index] into cpu_instruction, set fetch_pc and misaligned_err=0, go to HOLD.
  - HOLD: cpu_instruction_RDY_BSY=1. cpu_instruction and fetch_pc stay stable until cpu_instr_accept=1 is sampled.
    - accept=1, pc_valid=1: start the next fetch as in IDLE (back-to-back). RDY_BSY drops for WAIT_STATES cycles; with WAIT_STATES=0 it stays 1 and the new instruction appears at that edge.
    - accept=1, pc_valid=0: go to IDLE, RDY_BSY=0.
    - accept=0: pc_valid is ignored.
- Latency: aligned request sampled at edge N gives RDY_BSY=1 after edge N+WAIT_STATES. With WAIT_STATES=0 it is valid right after edge N.
- fetch_flush, any state: next state IDLE, RDY_BSY=0, fetch_busy=0, counter cleared.
  - Priority over pc_valid and accept in the same cycle.
  - cpu_instruction and fetch_pc keep their last values.
  - A request in the flush cycle is dropped; the CPU must re-present it the next cycle.
- Memory load is legal in any state and writes at the edge.
  - A capture reading the same word at the same edge returns the old contents (read-before-write).
- Priority: cpu_rst > fetch_flush > accept/pc_valid.

Test Plan:
- Reset: hold cpu_rst 2 cycles, then release → RDY_BSY=0, cpu_instruction=32'h00000013, fetch_pc=0, misaligned_err=0.
- Basic fetch, WAIT_STATES=1: load word 0=32'h00500093 (addi x1,x0,5), word 1=32'h00508113. pc_addr=0, pc_valid pulse at edge N → RDY_BSY=1 after N+1, instruction=32'h00500093, fetch_pc=0. Hold 3 cycles without accept → stable.
- Back-to-back: in HOLD, accept=1 with pc_addr=4, pc_valid=1 → RDY_BSY low 1 cycle, then 32'h00508113, fetch_pc=4. Repeat with WAIT_STATES=0 → RDY_BSY never drops.
- Flush: pc_addr=8 request, assert fetch_flush in WAIT together with a new pc_valid (pc_addr=12) → IDLE, RDY_BSY=0, nothing delivered. Re-request 12 → word 3 delivered.
- Misaligned/wrap: pc_addr=32'h6 → NOP_INSTR, misaligned_err=1, fetch_pc=6. pc_addr=DEPTH*4+4 (1028) → word 1 delivered.
- Load collision: capture word 2 at the same edge as load_we to word 2 with 32'hDEADBEEF → old value delivered; a refetch returns 32'hDEADBEEF.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction-side fetch responder: loadable instruction memory serving PC requests through a
// request/hold/accept handshake with configurable wait states and branch flush.
module instr_fetch_unit #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic [31:0]       pc_addr,
  input  logic              pc_valid,
  input  logic              fetch_flush,
  input  logic              cpu_instr_accept,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic [31:0]       cpu_instruction,
  output logic              cpu_instruction_RDY_BSY,
  output logic [31:0]       fetch_pc,
  output logic              misaligned_err,
  output logic              fetch_busy
);

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  localparam logic [3:0] WsLast = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  state_e      st_q, st_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        mis_q, mis_d;
  logic        start;

  logic [31:0] mem_q [DEPTH];

  function automatic logic [ADDR_W-1:0] word_idx(input logic [31:0] a);
    return a[ADDR_W+1:2];
  endfunction

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    mis_d   = mis_q;
    start   = 1'b0;
    if (fetch_flush) begin
      // Drop everything in flight but leave the last delivered instruction visible.
      st_d  = StIdle;
      cnt_d = '0;
    end else begin
      unique case (st_q)
        StIdle: start = pc_valid;
        StWait: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            instr_d = mem_q[word_idx(addr_q)];
            pc_d    = addr_q;
            mis_d   = 1'b0;
            st_d    = StHold;
          end
        end
        StHold: begin
          if (cpu_instr_accept) begin
            start = pc_valid;
            st_d  = StIdle;
          end
        end
        default: st_d = StIdle;
      endcase
      if (start) begin
        if (pc_addr[1:0] != 2'b00) begin
          instr_d = NOP_INSTR;
          pc_d    = pc_addr;
          mis_d   = 1'b1;
          st_d    = StHold;
        end else if (WAIT_STATES == 0) begin
          instr_d = mem_q[word_idx(pc_addr)];
          pc_d    = pc_addr;
          mis_d   = 1'b0;
          st_d    = StHold;
        end else begin
          addr_d = pc_addr;
          cnt_d  = WsLast;
          st_d   = StWait;
        end
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      st_q    <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  // Memory is deliberately outside reset; reads above see the pre-write contents.
  always_ff @(posedge cpu_clk) begin
    if (load_we) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign cpu_instruction         = instr_q;
  assign cpu_instruction_RDY_BSY = (st_q == StHold);
  assign fetch_pc                = pc_q;
  assign misaligned_err          = mis_q;
  assign fetch_busy              = (st_q == StWait);

endmodule
